seven_seg_mux: RTL
==================

// Module: seven_seg_mux
// PURPOSE
//  Time-multiplexes two 4-bit hex digits onto one shared display_controller
//    decoder and two common-anode 7-segment digits.
//  Sits directly upstream of display_controller: drives its s input and the
//    two anode enables.
//  A blanking interval separates digit switches so no ghosting occurs while
//    the decoder output settles.
// PARAMETERS
//  SHOW_CYCLES   24000  clk cycles a digit is lit per visit; must be >= 1
//  BLANK_CYCLES  480    clk cycles both anodes off before each digit; 0 = no blanking
// PORTS
//  clk          input   1  system clock
//  reset        input   1  synchronous reset, active-low
//  digit0       input   4  hex value for digit 0 (right)
//  digit1       input   4  hex value for digit 1 (left)
//  s            output  4  hex value to display_controller.s
//  an0_n        output  1  anode enable digit 0, active-low
//  an1_n        output  1  anode enable digit 1, active-low
//  digit_sel    output  1  0 = digit0 phase, 1 = digit1 phase
//  frame_start  output  1  1-cycle pulse at start of each 2-digit frame
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//   - state=BLANK0, cnt=0, s=4'h0
//   - an0_n=an1_n=1, digit_sel=0, frame_start=0
//  States: BLANK0 -> SHOW0 -> BLANK1 -> SHOW1 -> BLANK0 ...
//   - One counter cnt, width $clog2(max(SHOW_CYCLES,BLANK_CYCLES)+1).
//   - cnt is cleared on every state change.
//  BLANK_k: stays while cnt < BLANK_CYCLES-1; at cnt==BLANK_CYCLES-1 -> SHOW_k.
//   - BLANK_CYCLES==0: BLANK states are never entered.
//   - SHOW0 -> SHOW1 -> SHOW0 directly in that case.
//   - A reset still enters BLANK0, which exits on the first active edge.
//  SHOW_k: stays while cnt < SHOW_CYCLES-1; at cnt==SHOW_CYCLES-1 -> next state.
//  s register:
//   - Loads digit_k on every edge whose next state is BLANK_k.
//   - Also loads digit_k on any edge entering SHOW_k from another state.
//   - Held constant for the whole SHOW_k interval, so input changes mid-show
//     do not tear the display.
//  Decoded from the state register only (no comb path from inputs):
//   - an0_n=0 iff state==SHOW0; an1_n=0 iff state==SHOW1.
//   - an0_n and an1_n are never both 0 in any cycle.
//   - digit_sel=1 iff state in {BLANK1,SHOW1}.
//  frame_start: registered; 1 in the first cycle of BLANK0 (or of SHOW0 when
//    BLANK_CYCLES==0) after SHOW1; not asserted after reset.
//  Frame period = 2*(SHOW_CYCLES+BLANK_CYCLES) cycles; each digit duty
//    = SHOW_CYCLES/period.
//  Reset mid-operation: the next edge forces the reset values regardless of
//    state or cnt; no partial anode pulse survives.
// TESTING (bench params SHOW_CYCLES=4, BLANK_CYCLES=2; checks at negedge)
//  1 Reset: hold reset=0 for 3 edges, digit0=4'h3, digit1=4'hA
//    -> an0_n=an1_n=1, s=0, digit_sel=0 throughout.
//  2 Release reset (edge 1 = first edge with reset=1):
//    - s=3 after edge 1.
//    - an0_n=0 after edges 2-5.
//    - Both anodes off after edges 6-7, with s=A and digit_sel=1 after edge 6.
//    - an1_n=0 after edges 8-11.
//    - frame_start=1 only after edge 12; period 12.
//  3 Change digit0 to 4'h7 mid-SHOW0 -> s stays 3 until the next BLANK0
//    load, then s=7.
//  4 Every cycle over 100 frames -> never an0_n==0 && an1_n==0; each anode
//    low exactly 4 of every 12 cycles.
//  5 Assert reset=0 during SHOW1 at cnt=2 -> next edge: an1_n=1, s=0,
//    state BLANK0; resume per scenario 2.
//  6 Rebuild with BLANK_CYCLES=0, SHOW_CYCLES=3
//    -> anodes alternate every 3 cycles with no both-off cycle; period 6.

Source files
------------

// File: rtl/seven_seg_mux_if.sv
// seven_seg_mux_if: digit inputs and display-drive outputs of seven_seg_mux
//   master: upstream source of digit0/digit1, observer of the display drive
//   slave : the multiplexer itself
interface seven_seg_mux_if;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] s;
  logic       an0_n;
  logic       an1_n;
  logic       digit_sel;
  logic       frame_start;
  modport master(output digit0, digit1, input s, an0_n, an1_n, digit_sel, frame_start);
  modport slave(input digit0, digit1, output s, an0_n, an1_n, digit_sel, frame_start);
endinterface

// File: rtl/seven_seg_mux.sv
// seven_seg_mux: time-multiplexes two hex digits onto one decoder and two common-anode digits
//   clk              system clock
//   reset            synchronous reset, active-low
//   bus.digit0/1     hex values for right/left digit
//   bus.s            hex value to the shared decoder, frozen during each show interval
//   bus.an0_n/an1_n  active-low anode enables, never both low
//   bus.digit_sel    0 during digit0 phase, 1 during digit1 phase
//   bus.frame_start  one-cycle pulse when a new two-digit frame begins
module seven_seg_mux #(
  parameter int SHOW_CYCLES  = 24000,
  parameter int BLANK_CYCLES = 480
) (
  input logic           clk,
  input logic           reset,
  seven_seg_mux_if.slave bus
);
  localparam int MX = SHOW_CYCLES > BLANK_CYCLES ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(MX + 1);
  typedef enum logic [1:0] {BLANK0, SHOW0, BLANK1, SHOW1} state_t;
  state_t        state, nxt;
  logic [CW-1:0] cnt;
  logic          blank_done, show_done;
  // with zero blanking the post-reset BLANK0 must still leave on the first edge
  assign blank_done = BLANK_CYCLES <= 1 || cnt == CW'(BLANK_CYCLES - 1);
  assign show_done  = cnt == CW'(SHOW_CYCLES - 1);
  always_comb begin
    nxt = state;
    case (state)
      BLANK0:  nxt = blank_done ? SHOW0 : BLANK0;
      SHOW0:   nxt = show_done ? (BLANK_CYCLES == 0 ? SHOW1 : BLANK1) : SHOW0;
      BLANK1:  nxt = blank_done ? SHOW1 : BLANK1;
      default: nxt = show_done ? (BLANK_CYCLES == 0 ? SHOW0 : BLANK0) : SHOW1;
    endcase
  end
  // outputs are registered from the next state so they line up with state
  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= BLANK0;
      cnt             <= '0;
      bus.s           <= 4'h0;
      bus.an0_n       <= 1'b1;
      bus.an1_n       <= 1'b1;
      bus.digit_sel   <= 1'b0;
      bus.frame_start <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= nxt != state ? '0 : cnt + CW'(1);
      // s only samples while blanking or on show entry, never mid-show
      if (nxt == BLANK0 || (nxt == SHOW0 && state != SHOW0))
        bus.s <= bus.digit0;
      else if (nxt == BLANK1 || (nxt == SHOW1 && state != SHOW1))
        bus.s <= bus.digit1;
      bus.an0_n       <= nxt != SHOW0;
      bus.an1_n       <= nxt != SHOW1;
      bus.digit_sel   <= nxt == BLANK1 || nxt == SHOW1;
      bus.frame_start <= state == SHOW1 && nxt != SHOW1;
    end
  end
endmodule
